tcm_arbiter: RTL and testbench

- Two-requester arbiter sitting directly in front of one single-port, byte-enabled TCM with 1-cycle read latency.
- Port 0 is the core load/store path; port 1 is the external/DMA slave path.
- Each cycle it grants at most one requester and drives the TCM enable/address/write fields.
- It routes the returned read data back to the owner of the previous grant and bounds port-1 starvation with a wait counter.

---
 rtl/tcm_arbiter.sv | 104 ++++++++++
 tb/tb_tcm_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/tcm_arbiter.sv
// Two-port arbiter in front of a single-port TCM with 1-cycle read latency.
// Port 0 (core) wins by default; port 1 (DMA) is guaranteed a grant after STARVE_MAX denials.
module tcm_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 15,
   parameter int STARVE_MAX = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,

   input  logic                    p0_req_i,
   input  logic                    p0_we_i,
   input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
   input  logic [DATA_WIDTH/8-1:0] p0_be_i,
   input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
   output logic                    p0_gnt_o,
   output logic                    p0_rvalid_o,
   output logic [DATA_WIDTH-1:0]   p0_rdata_o,

   input  logic                    p1_req_i,
   input  logic                    p1_we_i,
   input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
   input  logic [DATA_WIDTH/8-1:0] p1_be_i,
   input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
   output logic                    p1_gnt_o,
   output logic                    p1_rvalid_o,
   output logic [DATA_WIDTH-1:0]   p1_rdata_o,

   output logic                    tcm_en_o,
   output logic                    tcm_we_o,
   output logic [ADDR_WIDTH-1:0]   tcm_addr_o,
   output logic [DATA_WIDTH/8-1:0] tcm_be_o,
   output logic [DATA_WIDTH-1:0]   tcm_wdata_o,
   input  logic [DATA_WIDTH-1:0]   tcm_rdata_i
);

   localparam int CNT_WIDTH = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_WIDTH-1:0] STARVE_LIM = CNT_WIDTH'(STARVE_MAX);

   logic [CNT_WIDTH-1:0] starve_cnt_q, starve_cnt_d;
   logic                 resp_pending_q, resp_pending_d;
   logic                 resp_owner_q, resp_owner_d;
   logic                 resp_read_q, resp_read_d;
   logic                 p1_wins;

   // Grants are gated by reset so nothing reaches the TCM while reset is held.
   assign p1_wins  = p1_req_i & (~p0_req_i | (starve_cnt_q == STARVE_LIM));
   assign p1_gnt_o = rst_ni & p1_wins;
   assign p0_gnt_o = rst_ni & p0_req_i & ~p1_wins;
   assign tcm_en_o = p0_gnt_o | p1_gnt_o;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      tcm_we_o    = 1'b0;
      tcm_addr_o  = '0;
      tcm_be_o    = '0;
      tcm_wdata_o = '0;
      if (p0_gnt_o) begin
         tcm_we_o    = p0_we_i;
         tcm_addr_o  = p0_addr_i;
         tcm_be_o    = p0_be_i;
         tcm_wdata_o = p0_wdata_i;
      end else if (p1_gnt_o) begin
         tcm_we_o    = p1_we_i;
         tcm_addr_o  = p1_addr_i;
         tcm_be_o    = p1_be_i;
         tcm_wdata_o = p1_wdata_i;
      end
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!p1_req_i || p1_gnt_o) begin
         starve_cnt_d = '0;
      end else if (starve_cnt_q != STARVE_LIM) begin
         starve_cnt_d = starve_cnt_q + CNT_WIDTH'(1);
      end
      resp_pending_d = tcm_en_o;
      resp_owner_d   = p1_gnt_o;
      resp_read_d    = tcm_en_o & ~tcm_we_o;
   end

   always_ff @(posedge clk_i) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_ni) begin
         starve_cnt_q   <= '0;
         resp_pending_q <= 1'b0;
         resp_owner_q   <= 1'b0;
         resp_read_q    <= 1'b0;
      end else begin
         starve_cnt_q   <= starve_cnt_d;
         resp_pending_q <= resp_pending_d;
         resp_owner_q   <= resp_owner_d;
         resp_read_q    <= resp_read_d;
      end
   end

   // A reset landing in the response cycle discards the outstanding response.
   assign p0_rvalid_o = rst_ni & resp_pending_q & ~resp_owner_q;
   assign p1_rvalid_o = rst_ni & resp_pending_q &  resp_owner_q;
   assign p0_rdata_o  = (p0_rvalid_o & resp_read_q) ? tcm_rdata_i : '0;
   assign p1_rdata_o  = (p1_rvalid_o & resp_read_q) ? tcm_rdata_i : '0;

endmodule

// File: tb/tb_tcm_arbiter.sv
// Directed bench for tcm_arbiter: stimulus checks grants and TCM drive, and queues
// expected responses that a separate monitor compares whenever rvalid is due or seen.
module tb_tcm_arbiter;

   localparam int DW = 32;
   localparam int AW = 15;
   localparam int BW = DW / 8;

   typedef struct packed {
      logic          req;
      logic          we;
      logic [AW-1:0] addr;
      logic [BW-1:0] be;
      logic [DW-1:0] wdata;
   } port_t;

   typedef struct {
      int            due;
      logic          owner;
      logic [DW-1:0] data;
   } resp_t;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          p0_req_i, p0_we_i, p1_req_i, p1_we_i;
   logic [AW-1:0] p0_addr_i, p1_addr_i, tcm_addr_o;
   logic [BW-1:0] p0_be_i, p1_be_i, tcm_be_o;
   logic [DW-1:0] p0_wdata_i, p1_wdata_i, tcm_wdata_o, tcm_rdata_i;
   logic          p0_gnt_o, p1_gnt_o, p0_rvalid_o, p1_rvalid_o;
   logic [DW-1:0] p0_rdata_o, p1_rdata_o;
   logic          tcm_en_o, tcm_we_o;

   int            n_cmp = 0;
   int            n_fail = 0;
   int            cyc = 0;
   resp_t         exp_q[$];
   resp_t         mon_item;
   logic [DW-1:0] rdata_next = '0;

   tcm_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_MAX(4)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .p0_req_i    (p0_req_i),
      .p0_we_i     (p0_we_i),
      .p0_addr_i   (p0_addr_i),
      .p0_be_i     (p0_be_i),
      .p0_wdata_i  (p0_wdata_i),
      .p0_gnt_o    (p0_gnt_o),
      .p0_rvalid_o (p0_rvalid_o),
      .p0_rdata_o  (p0_rdata_o),
      .p1_req_i    (p1_req_i),
      .p1_we_i     (p1_we_i),
      .p1_addr_i   (p1_addr_i),
      .p1_be_i     (p1_be_i),
      .p1_wdata_i  (p1_wdata_i),
      .p1_gnt_o    (p1_gnt_o),
      .p1_rvalid_o (p1_rvalid_o),
      .p1_rdata_o  (p1_rdata_o),
      .tcm_en_o    (tcm_en_o),
      .tcm_we_o    (tcm_we_o),
      .tcm_addr_o  (tcm_addr_o),
      .tcm_be_o    (tcm_be_o),
      .tcm_wdata_o (tcm_wdata_o),
      .tcm_rdata_i (tcm_rdata_i)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic port_t rd(input logic [AW-1:0] a);
      port_t p;
      p = '{req: 1'b1, we: 1'b0, addr: a, be: '1, wdata: '0};
      return p;
   endfunction

   function automatic port_t wr(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [DW-1:0] d);
      port_t p;
      p = '{req: 1'b1, we: 1'b1, addr: a, be: b, wdata: d};
      return p;
   endfunction

   localparam port_t NONE = '0;

   // One clock cycle: drive inputs, check grant and TCM drive mid-cycle, queue the response.
   // rd_next is the word the TCM model returns in the following cycle.
   task automatic step(input string name, input logic rst, input port_t a, input port_t b,
                       input logic [1:0] exp_gnt, input logic [DW-1:0] rd_next);
      port_t win;
      resp_t item;
      rst_ni      = rst;
      p0_req_i    = a.req;  p0_we_i = a.we;  p0_addr_i = a.addr;  p0_be_i = a.be;  p0_wdata_i = a.wdata;
      p1_req_i    = b.req;  p1_we_i = b.we;  p1_addr_i = b.addr;  p1_be_i = b.be;  p1_wdata_i = b.wdata;
      tcm_rdata_i = rdata_next;
      rdata_next  = rd_next;
      @(negedge clk_i);
      check({name, "/gnt"}, {62'd0, p1_gnt_o, p0_gnt_o}, {62'd0, exp_gnt});
      win = exp_gnt[0] ? a : (exp_gnt[1] ? b : NONE);
      check({name, "/tcm"}, {tcm_en_o, tcm_we_o, tcm_addr_o, tcm_be_o, tcm_wdata_o},
            {|exp_gnt, win.we, win.addr, win.be, win.wdata});
      if (!rst) check({name, "/rvalid_in_reset"}, {62'd0, p1_rvalid_o, p0_rvalid_o}, 64'd0);
      if (exp_gnt != 2'b00) begin
         item.due   = cyc + 1;
         item.owner = exp_gnt[1];
         item.data  = win.we ? '0 : rd_next;
         exp_q.push_back(item);
      end
      @(posedge clk_i);
      #1;
   endtask

   always @(negedge clk_i) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         mon_item = exp_q.pop_front();
         if (!rst_ni) begin
            check("resp/discarded", {62'd0, p1_rvalid_o, p0_rvalid_o}, 64'd0);
         end else begin
            check("resp/rvalid", {62'd0, p1_rvalid_o, p0_rvalid_o},
                  {62'd0, mon_item.owner, ~mon_item.owner});
            check("resp/rdata", {p1_rdata_o, p0_rdata_o},
                  mon_item.owner ? {mon_item.data, 32'h0} : {32'h0, mon_item.data});
         end
      end else if (p0_rvalid_o || p1_rvalid_o) begin
         check("resp/spurious", {62'd0, p1_rvalid_o, p0_rvalid_o}, 64'd0);
      end
   end

   initial begin
      rst_ni = 1'b0;
      {p0_req_i, p0_we_i, p0_addr_i, p0_be_i, p0_wdata_i} = '0;
      {p1_req_i, p1_we_i, p1_addr_i, p1_be_i, p1_wdata_i} = '0;
      tcm_rdata_i = '0;
      @(posedge clk_i);
      #1;

      for (int i = 0; i < 3; i++) step("reset", 1'b0, rd(15'h0004), rd(15'h0008), 2'b00, '0);

      // Both ports saturating the TCM: p1 wins every fifth cycle.
      for (int i = 0; i < 10; i++)
         step("starve", 1'b1, rd(15'h0004), rd(15'h0008), (i % 5 == 4) ? 2'b10 : 2'b01, 32'h1000_0000 + i);
      step("idle", 1'b1, NONE, NONE, 2'b00, '0);

      step("single_read", 1'b1, rd(15'h0010), NONE, 2'b01, 32'hDEAD_BEEF);
      step("idle", 1'b1, NONE, NONE, 2'b00, '0);

      step("byte_write", 1'b1, NONE, wr(15'h0100, 4'b0100, 32'h00AA_0000), 2'b10, 32'h5555_5555);

      step("b2b_p0", 1'b1, rd(15'h0020), NONE, 2'b01, 32'hA000_0000);
      step("b2b_p1", 1'b1, NONE, rd(15'h0024), 2'b10, 32'hA000_0001);
      step("b2b_p0", 1'b1, rd(15'h0028), NONE, 2'b01, 32'hA000_0002);
      step("idle", 1'b1, NONE, NONE, 2'b00, '0);

      // p1 withdrawing clears the count: the full 4-cycle wait starts over.
      step("drop_both", 1'b1, rd(15'h0030), rd(15'h0034), 2'b01, 32'hB000_0000);
      step("drop_both", 1'b1, rd(15'h0030), rd(15'h0034), 2'b01, 32'hB000_0001);
      step("drop_p0", 1'b1, rd(15'h0030), NONE, 2'b01, 32'hB000_0002);
      for (int i = 0; i < 5; i++)
         step("drop_refill", 1'b1, rd(15'h0030), rd(15'h0034), (i == 4) ? 2'b10 : 2'b01, 32'hB100_0000 + i);

      // Reset in the response cycle discards it and clears the partial count.
      step("mid_both", 1'b1, rd(15'h0040), rd(15'h0044), 2'b01, 32'hC000_0000);
      step("mid_both", 1'b1, rd(15'h0040), rd(15'h0044), 2'b01, 32'hC000_0001);
      step("mid_reset", 1'b0, rd(15'h0040), rd(15'h0044), 2'b00, '0);
      for (int i = 0; i < 5; i++)
         step("post_reset", 1'b1, rd(15'h0040), rd(15'h0044), (i == 4) ? 2'b10 : 2'b01, 32'hC100_0000 + i);

      step("p0_write", 1'b1, wr(15'h0050, 4'hF, 32'h1234_5678), NONE, 2'b01, 32'h0000_0077);
      step("idle", 1'b1, NONE, NONE, 2'b00, '0);
      step("idle", 1'b1, NONE, NONE, 2'b00, '0);

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
